// File: rtl/dfi_pkg.sv
// Shared DFI command definitions: opcodes, DDR3 ras/cas/we encoding and sizing helpers.
package dfi_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_ACT = 3'd1,
      OP_RD  = 3'd2,
      OP_WR  = 3'd3,
      OP_PRE = 3'd4,
      OP_REF = 3'd5,
      OP_MRS = 3'd6,
      OP_ZQ  = 3'd7
   } dfi_op_e;

   typedef struct packed {
      logic ras_n;
      logic cas_n;
      logic we_n;
   } dfi_rcw_t;

   localparam dfi_rcw_t RCW_NOP = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};

   // JEDEC DDR3 ras_n/cas_n/we_n truth table
   function automatic dfi_rcw_t op_to_rcw(input dfi_op_e op);
      case (op)
         OP_ACT:  return dfi_rcw_t'(3'b011);
         OP_RD:   return dfi_rcw_t'(3'b101);
         OP_WR:   return dfi_rcw_t'(3'b100);
         OP_PRE:  return dfi_rcw_t'(3'b010);
         OP_REF:  return dfi_rcw_t'(3'b001);
         OP_MRS:  return dfi_rcw_t'(3'b000);
         OP_ZQ:   return dfi_rcw_t'(3'b110);
         default: return RCW_NOP;
      endcase
   endfunction

   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned r;
      r = $clog2(v);
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/dfi_if.sv
// DFI control-side bundle: command, enable and update signals for a multi-phase PHY.
interface dfi_if #(
   parameter int unsigned C_DFI_FREQ_RATIO = 4,
   parameter int unsigned C_DFI_ADDR_WIDTH = 14,
   parameter int unsigned C_DFI_BANK_WIDTH = 3,
   parameter int unsigned C_DFI_CS_WIDTH   = 1
);
   logic [C_DFI_FREQ_RATIO*C_DFI_ADDR_WIDTH-1:0] dfi_address;
   logic [C_DFI_FREQ_RATIO*C_DFI_BANK_WIDTH-1:0] dfi_bank;
   logic [C_DFI_FREQ_RATIO*C_DFI_CS_WIDTH-1:0]   dfi_cs_n;
   logic [C_DFI_FREQ_RATIO-1:0]                  dfi_ras_n;
   logic [C_DFI_FREQ_RATIO-1:0]                  dfi_cas_n;
   logic [C_DFI_FREQ_RATIO-1:0]                  dfi_we_n;
   logic [C_DFI_FREQ_RATIO*C_DFI_CS_WIDTH-1:0]   dfi_cke;
   logic [C_DFI_FREQ_RATIO*C_DFI_CS_WIDTH-1:0]   dfi_odt;
   logic                                         dfi_reset_n;
   logic [C_DFI_FREQ_RATIO-1:0]                  dfi_wrdata_en;
   logic [C_DFI_FREQ_RATIO*C_DFI_CS_WIDTH-1:0]   dfi_wrdata_cs_n;
   logic [C_DFI_FREQ_RATIO-1:0]                  dfi_rddata_en;
   logic [C_DFI_FREQ_RATIO*C_DFI_CS_WIDTH-1:0]   dfi_rddata_cs_n;
   logic                                         dfi_ctrlupd_req;
   logic                                         dfi_ctrlupd_ack;
   logic                                         dfi_init_complete;
   logic [1:0]                                   dfi_freq_ratio;
   logic                                         dfi_phyupd_ack;
   logic                                         dfi_lp_ctrl_req;
   logic [C_DFI_CS_WIDTH-1:0]                    dfi_dram_clk_disable;

   modport master (
      output dfi_address, dfi_bank, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
             dfi_cke, dfi_odt, dfi_reset_n, dfi_wrdata_en, dfi_wrdata_cs_n,
             dfi_rddata_en, dfi_rddata_cs_n, dfi_ctrlupd_req, dfi_freq_ratio,
             dfi_phyupd_ack, dfi_lp_ctrl_req, dfi_dram_clk_disable,
      input  dfi_ctrlupd_ack, dfi_init_complete
   );
endinterface

// File: rtl/dfi_en_shifter.sv
// Phase-granular enable window generator: bit i of the register is absolute phase clk*R+i.
module dfi_en_shifter import dfi_pkg::*; #(
   parameter int unsigned C_RATIO    = 4,
   parameter int unsigned C_LAT      = 5,
   parameter int unsigned C_BURST    = 4,
   parameter int unsigned C_CS_WIDTH = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               load,
   input  logic [clog2_min1(C_RATIO)-1:0]     phase,
   input  logic [C_CS_WIDTH-1:0]              cs,
   output logic [C_RATIO-1:0]                 en,
   output logic [C_RATIO*C_CS_WIDTH-1:0]      cs_sel,
   output logic                               busy
);
   localparam int unsigned N = C_RATIO + C_LAT + C_BURST;

   logic [N-1:0]            en_sr, en_ld;
   logic [N*C_CS_WIDTH-1:0] cs_sr, cs_ld;
   int unsigned             lo, hi;

   // Load offsets are relative to the first phase of the next clk
   always_comb begin
      en_ld = '0;
      cs_ld = '0;
      lo    = C_LAT + 32'(phase);
      hi    = lo + C_BURST;
      for (int unsigned i = 0; i < N; i++) begin
         if (load && (i >= lo) && (i < hi)) begin
            en_ld[i]                          = 1'b1;
            cs_ld[i*C_CS_WIDTH +: C_CS_WIDTH] = cs;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_sr <= '0;
         cs_sr <= '0;
      end else begin
         en_sr <= (en_sr >> C_RATIO) | en_ld;
         cs_sr <= (cs_sr >> (C_RATIO*C_CS_WIDTH)) | cs_ld;
      end
   end

   assign en     = en_sr[C_RATIO-1:0];
   assign cs_sel = cs_sr[C_RATIO*C_CS_WIDTH-1:0];
   assign busy   = |en_sr;

endmodule

// File: rtl/dfi_cmd_packer.sv
// Packs controller commands onto DFI phases, generates data enables and runs ctrlupd handshakes.
// Optional DFI_CMD_ODT_EN adds per-chip-select ODT around write windows.
module dfi_cmd_packer import dfi_pkg::*; #(
   parameter int unsigned C_DFI_FREQ_RATIO = 4,
   parameter int unsigned C_DFI_ADDR_WIDTH = 14,
   parameter int unsigned C_DFI_BANK_WIDTH = 3,
   parameter int unsigned C_DFI_CS_WIDTH   = 1,
   parameter int unsigned C_WRLAT          = 5,
   parameter int unsigned C_RDLAT          = 7,
   parameter int unsigned C_BURST_PHASES   = 4,
   parameter int unsigned C_UPD_TIMEOUT    = 64
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      cmd_valid,
   output logic                                      cmd_ready,
   input  logic [2:0]                                cmd_op,
   input  logic [clog2_min1(C_DFI_FREQ_RATIO)-1:0]   cmd_phase,
   input  logic [C_DFI_ADDR_WIDTH-1:0]               cmd_addr,
   input  logic [C_DFI_BANK_WIDTH-1:0]               cmd_bank,
   input  logic [C_DFI_CS_WIDTH-1:0]                 cmd_cs,
   input  logic                                      cke_in,
   input  logic                                      upd_req,
   output logic                                      upd_done,
   output logic                                      upd_timeout,
   dfi_if.master                                     dfi
);
   localparam int unsigned R   = C_DFI_FREQ_RATIO;
   localparam int unsigned AW  = C_DFI_ADDR_WIDTH;
   localparam int unsigned BW  = C_DFI_BANK_WIDTH;
   localparam int unsigned CSW = C_DFI_CS_WIDTH;
   localparam int unsigned CW  = clog2_min1(C_UPD_TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_REQ, ST_DONE} upd_state_e;

   upd_state_e       state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             set_timeout, ctrlupd_q;
   logic             accept, run_q, cmd_reg_q;
   dfi_op_e          op;
   dfi_rcw_t         rcw;
   logic [R*CSW-1:0] cs_n_q, cke_q, wr_cs, rd_cs, odt_q;
   logic [R-1:0]     ras_n_q, cas_n_q, we_n_q, wr_en, rd_en;
   logic [R*AW-1:0]  addr_q;
   logic [R*BW-1:0]  bank_q;
   logic             wr_busy, rd_busy, odt_busy;

   assign op        = dfi_op_e'(cmd_op);
   assign rcw       = op_to_rcw(op);
   assign cmd_ready = run_q && dfi.dfi_init_complete && (state == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Command slot: target phase carries the command, every other phase a NOP
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_n_q    <= '1;
         ras_n_q   <= '1;
         cas_n_q   <= '1;
         we_n_q    <= '1;
         addr_q    <= '0;
         bank_q    <= '0;
         cke_q     <= '0;
         run_q     <= 1'b0;
         cmd_reg_q <= 1'b0;
      end else begin
         cs_n_q    <= '1;
         ras_n_q   <= {R{RCW_NOP.ras_n}};
         cas_n_q   <= {R{RCW_NOP.cas_n}};
         we_n_q    <= {R{RCW_NOP.we_n}};
         cke_q     <= {(R*CSW){cke_in}};
         run_q     <= 1'b1;
         cmd_reg_q <= accept;
         if (accept && (op != OP_NOP)) begin
            cs_n_q[cmd_phase*CSW +: CSW] <= ~cmd_cs;
            ras_n_q[cmd_phase]           <= rcw.ras_n;
            cas_n_q[cmd_phase]           <= rcw.cas_n;
            we_n_q[cmd_phase]            <= rcw.we_n;
            addr_q[cmd_phase*AW +: AW]   <= cmd_addr;
            bank_q[cmd_phase*BW +: BW]   <= cmd_bank;
         end
      end
   end

   dfi_en_shifter #(.C_RATIO(R), .C_LAT(C_WRLAT), .C_BURST(C_BURST_PHASES), .C_CS_WIDTH(CSW)) u_wr (
      .clk(clk), .rst(rst), .load(accept && (op == OP_WR)), .phase(cmd_phase), .cs(cmd_cs),
      .en(wr_en), .cs_sel(wr_cs), .busy(wr_busy));

   dfi_en_shifter #(.C_RATIO(R), .C_LAT(C_RDLAT), .C_BURST(C_BURST_PHASES), .C_CS_WIDTH(CSW)) u_rd (
      .clk(clk), .rst(rst), .load(accept && (op == OP_RD)), .phase(cmd_phase), .cs(cmd_cs),
      .en(rd_en), .cs_sel(rd_cs), .busy(rd_busy));

`ifdef DFI_CMD_ODT_EN
   // ODT lead is clipped when the write latency leaves fewer than two phases
   localparam int unsigned ODT_LEAD = (C_WRLAT >= 2) ? 2 : C_WRLAT;
   logic [R-1:0]     odt_en;
   logic [R*CSW-1:0] odt_cs;

   dfi_en_shifter #(.C_RATIO(R), .C_LAT(C_WRLAT - ODT_LEAD), .C_BURST(C_BURST_PHASES + ODT_LEAD + 2),
                    .C_CS_WIDTH(CSW)) u_odt (
      .clk(clk), .rst(rst), .load(accept && (op == OP_WR)), .phase(cmd_phase), .cs(cmd_cs),
      .en(odt_en), .cs_sel(odt_cs), .busy(odt_busy));

   always_comb begin
      odt_q = '0;
      for (int unsigned p = 0; p < R; p++) odt_q[p*CSW +: CSW] = odt_cs[p*CSW +: CSW] & {CSW{odt_en[p]}};
   end
`else
   assign odt_q    = '0;
   assign odt_busy = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         ctrlupd_q   <= 1'b0;
         upd_done    <= 1'b0;
         upd_timeout <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         ctrlupd_q <= (state_nx == ST_REQ);
         upd_done  <= (state_nx == ST_DONE);
         if (set_timeout) upd_timeout <= 1'b1;
      end
   end

   // Update handshake: drain all in-flight traffic before raising ctrlupd_req
   always_comb begin
      state_nx    = state;
      cnt_nx      = '0;
      set_timeout = 1'b0;
      case (state)
         ST_IDLE:  if (upd_req) state_nx = ST_DRAIN;
         ST_DRAIN: if (!wr_busy && !rd_busy && !odt_busy && !cmd_reg_q) state_nx = ST_REQ;
         ST_REQ: begin
            if (dfi.dfi_ctrlupd_ack) begin
               state_nx = ST_DONE;
            end else if (cnt == CW'(C_UPD_TIMEOUT - 1)) begin
               state_nx    = ST_DONE;
               set_timeout = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   assign dfi.dfi_address          = addr_q;
   assign dfi.dfi_bank             = bank_q;
   assign dfi.dfi_cs_n             = cs_n_q;
   assign dfi.dfi_ras_n            = ras_n_q;
   assign dfi.dfi_cas_n            = cas_n_q;
   assign dfi.dfi_we_n             = we_n_q;
   assign dfi.dfi_cke              = cke_q;
   assign dfi.dfi_odt              = odt_q;
   assign dfi.dfi_reset_n          = run_q;
   assign dfi.dfi_wrdata_en        = wr_en;
   assign dfi.dfi_wrdata_cs_n      = ~wr_cs;
   assign dfi.dfi_rddata_en        = rd_en;
   assign dfi.dfi_rddata_cs_n      = ~rd_cs;
   assign dfi.dfi_ctrlupd_req      = ctrlupd_q;
   assign dfi.dfi_freq_ratio       = 2'($clog2(R));
   assign dfi.dfi_phyupd_ack       = 1'b0;
   assign dfi.dfi_lp_ctrl_req      = 1'b0;
   assign dfi.dfi_dram_clk_disable = '0;

endmodule

// File: tb/tb_dfi_cmd_packer.sv
// Directed bench for dfi_cmd_packer at R=4, WRLAT=5, RDLAT=7, burst 4, timeout 64.
module tb_dfi_cmd_packer;
   import dfi_pkg::*;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, cke_in, upd_req, upd_done, upd_timeout;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_phase;
   logic [13:0] cmd_addr;
   logic [2:0]  cmd_bank;
   logic [0:0]  cmd_cs;
   int          tests = 0;
   int          fails = 0;
   int          held;

   dfi_if #(.C_DFI_FREQ_RATIO(4), .C_DFI_ADDR_WIDTH(14), .C_DFI_BANK_WIDTH(3), .C_DFI_CS_WIDTH(1)) dfi_bus ();

   dfi_cmd_packer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_phase(cmd_phase), .cmd_addr(cmd_addr), .cmd_bank(cmd_bank), .cmd_cs(cmd_cs),
      .cke_in(cke_in), .upd_req(upd_req), .upd_done(upd_done), .upd_timeout(upd_timeout),
      .dfi(dfi_bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input dfi_op_e op, input logic [1:0] ph, input logic [13:0] a, input logic [2:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_phase = ph;
      cmd_addr  = a;
      cmd_bank  = b;
      cmd_cs    = 1'b1;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_phase = 2'd0; cmd_addr = '0;
      cmd_bank = '0; cmd_cs = 1'b0; cke_in = 1'b0; upd_req = 1'b0;
      dfi_bus.dfi_init_complete = 1'b0;
      dfi_bus.dfi_ctrlupd_ack   = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_ready",   64'(cmd_ready), 64'h0);
      check("rst_done",    64'(upd_done), 64'h0);
      check("rst_tmo",     64'(upd_timeout), 64'h0);
      check("rst_cs_n",    64'(dfi_bus.dfi_cs_n), 64'hF);
      check("rst_ras_n",   64'(dfi_bus.dfi_ras_n), 64'hF);
      check("rst_addr",    64'(dfi_bus.dfi_address), 64'h0);
      check("rst_cke",     64'(dfi_bus.dfi_cke), 64'h0);
      check("rst_reset_n", 64'(dfi_bus.dfi_reset_n), 64'h0);
      check("rst_wr_en",   64'(dfi_bus.dfi_wrdata_en), 64'h0);
      check("rst_rd_en",   64'(dfi_bus.dfi_rddata_en), 64'h0);
      check("rst_upd_req", 64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      check("freq_ratio",  64'(dfi_bus.dfi_freq_ratio), 64'h2);
      check("odt_off",     64'(dfi_bus.dfi_odt), 64'h0);

      rst = 1'b0; cke_in = 1'b1;
      tick();
      check("reset_n_rel", 64'(dfi_bus.dfi_reset_n), 64'h1);
      check("cke_reg",     64'(dfi_bus.dfi_cke), 64'hF);
      check("ready_noinit", 64'(cmd_ready), 64'h0);
      dfi_bus.dfi_init_complete = 1'b1;
      #1;
      check("ready_init",  64'(cmd_ready), 64'h1);

      // ACT on phase 2
      drive(OP_ACT, 2'd2, 14'h1234, 3'd5);
      tick();
      cmd_valid = 1'b0;
      check("act_cs_n",  64'(dfi_bus.dfi_cs_n), 64'b1011);
      check("act_ras_n", 64'(dfi_bus.dfi_ras_n), 64'b1011);
      check("act_cas_n", 64'(dfi_bus.dfi_cas_n), 64'hF);
      check("act_we_n",  64'(dfi_bus.dfi_we_n), 64'hF);
      check("act_addr",  64'(dfi_bus.dfi_address), 64'h1234 << 28);
      check("act_bank",  64'(dfi_bus.dfi_bank), 64'h5 << 6);
      tick();
      check("nop_cs_n",  64'(dfi_bus.dfi_cs_n), 64'hF);
      check("nop_ras_n", 64'(dfi_bus.dfi_ras_n), 64'hF);
      check("addr_hold", 64'(dfi_bus.dfi_address), 64'h1234 << 28);

      // WR on phase 1: enables at +2 cycles phases 2,3 and +3 cycles phases 0,1
      drive(OP_WR, 2'd1, 14'h0ABC, 3'd1);
      tick();
      cmd_valid = 1'b0;
      check("wr_cs_n",   64'(dfi_bus.dfi_cs_n), 64'b1101);
      check("wr_ras_n",  64'(dfi_bus.dfi_ras_n), 64'hF);
      check("wr_cas_n",  64'(dfi_bus.dfi_cas_n), 64'b1101);
      check("wr_we_n",   64'(dfi_bus.dfi_we_n), 64'b1101);
      check("wr_en_c1",  64'(dfi_bus.dfi_wrdata_en), 64'h0);
      tick();
      check("wr_en_c2",  64'(dfi_bus.dfi_wrdata_en), 64'b1100);
      check("wr_csn_c2", 64'(dfi_bus.dfi_wrdata_cs_n), 64'b0011);
      tick();
      check("wr_en_c3",  64'(dfi_bus.dfi_wrdata_en), 64'b0011);
      check("wr_csn_c3", 64'(dfi_bus.dfi_wrdata_cs_n), 64'b1100);
      tick();
      check("wr_en_c4",  64'(dfi_bus.dfi_wrdata_en), 64'h0);
      check("wr_csn_c4", 64'(dfi_bus.dfi_wrdata_cs_n), 64'hF);

      // Back-to-back RDs on phase 0: eight contiguous rddata_en phases
      drive(OP_RD, 2'd0, 14'h0011, 3'd2);
      tick();
      check("rd1_cas_n", 64'(dfi_bus.dfi_cas_n), 64'b1110);
      tick();
      cmd_valid = 1'b0;
      check("rd2_cas_n", 64'(dfi_bus.dfi_cas_n), 64'b1110);
      check("rd2_we_n",  64'(dfi_bus.dfi_we_n), 64'hF);
      check("rd_en_a",   64'(dfi_bus.dfi_rddata_en), 64'b1000);
      tick();
      check("rd_en_b",   64'(dfi_bus.dfi_rddata_en), 64'hF);
      check("rd_csn_b",  64'(dfi_bus.dfi_rddata_cs_n), 64'h0);
      tick();
      check("rd_en_c",   64'(dfi_bus.dfi_rddata_en), 64'b0111);
      tick();
      check("rd_en_d",   64'(dfi_bus.dfi_rddata_en), 64'h0);

      // Update request together with an RD: command accepted, then drain
      drive(OP_RD, 2'd0, 14'h0022, 3'd3);
      upd_req = 1'b1;
      tick();
      cmd_valid = 1'b0; upd_req = 1'b0;
      check("drain_ready", 64'(cmd_ready), 64'h0);
      check("drain_req1",  64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      tick();
      check("drain_req2",  64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      check("drain_rd2",   64'(dfi_bus.dfi_rddata_en), 64'b1000);
      tick();
      check("drain_req3",  64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      check("drain_rd3",   64'(dfi_bus.dfi_rddata_en), 64'b0111);
      tick();
      check("drain_req4",  64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      tick();
      check("upd_req_on",  64'(dfi_bus.dfi_ctrlupd_req), 64'h1);
      upd_req = 1'b1;
      tick();
      upd_req = 1'b0;
      check("upd_req_h2",  64'(dfi_bus.dfi_ctrlupd_req), 64'h1);
      tick();
      check("upd_req_h3",  64'(dfi_bus.dfi_ctrlupd_req), 64'h1);
      tick();
      check("upd_req_h4",  64'(dfi_bus.dfi_ctrlupd_req), 64'h1);
      dfi_bus.dfi_ctrlupd_ack = 1'b1;
      tick();
      dfi_bus.dfi_ctrlupd_ack = 1'b0;
      check("ack_req_off", 64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      check("ack_done",    64'(upd_done), 64'h1);
      check("ack_ready0",  64'(cmd_ready), 64'h0);
      tick();
      check("ack_done_end", 64'(upd_done), 64'h0);
      check("ack_ready1",  64'(cmd_ready), 64'h1);
      check("ack_no_tmo",  64'(upd_timeout), 64'h0);

      // No ack: ctrlupd_req held for the full timeout
      upd_req = 1'b1;
      tick();
      upd_req = 1'b0;
      check("tmo_drain",   64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      held = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (dfi_bus.dfi_ctrlupd_req === 1'b1) held++;
      end
      check("tmo_held",    64'(held), 64'd64);
      tick();
      check("tmo_req_off", 64'(dfi_bus.dfi_ctrlupd_req), 64'h0);
      check("tmo_flag",    64'(upd_timeout), 64'h1);
      check("tmo_done",    64'(upd_done), 64'h1);
      tick();
      check("tmo_ready",   64'(cmd_ready), 64'h1);
      check("tmo_sticky",  64'(upd_timeout), 64'h1);

      // Reset in the middle of a write window
      drive(OP_WR, 2'd0, 14'h0033, 3'd4);
      tick();
      cmd_valid = 1'b0;
      tick();
      check("mid_wr_en",   64'(dfi_bus.dfi_wrdata_en), 64'b1110);
      check("mid_wr_csn",  64'(dfi_bus.dfi_wrdata_cs_n), 64'b0001);
      rst = 1'b1;
      tick();
      check("rst_wr_cut",  64'(dfi_bus.dfi_wrdata_en), 64'h0);
      check("rst_wr_csn",  64'(dfi_bus.dfi_wrdata_cs_n), 64'hF);
      check("rst_cs_n2",   64'(dfi_bus.dfi_cs_n), 64'hF);
      check("rst_ready2",  64'(cmd_ready), 64'h0);
      check("rst_tmo_clr", 64'(upd_timeout), 64'h0);
      rst = 1'b0;
      tick();
      check("post_wr_en",  64'(dfi_bus.dfi_wrdata_en), 64'h0);
      check("post_rstn",   64'(dfi_bus.dfi_reset_n), 64'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
